// File: rtl/aha_loop_back_pkg.sv
// Shared definitions for the loop-back frequency monitor.
// Holds the FSM state encodings and the default field widths used by
// aha_loop_back_monitor and aha_sync_edge_det.
package aha_loop_back_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/aha_sync_edge_det.sv
// Synchronizer plus rising-edge detector for an asynchronous input.
// Ports:
//   CLK     - reference clock
//   RESET   - synchronous active-high reset, clears every flop
//   D_ASYNC - asynchronous input (selected clock / debug signal)
//   EDGE    - one-cycle pulse per synchronized rising edge of D_ASYNC
module aha_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic D_ASYNC,
  output logic EDGE
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], D_ASYNC};
      r_prev <= w_sync_out;
    end
  end

  assign EDGE = w_sync_out & ~r_prev;

endmodule

// File: rtl/aha_loop_back_monitor.sv
// Loop-back frequency monitor: counts rising edges of LOOP_BACK over a
// programmable window of CLK cycles.
// Ports:
//   CLK, RESET          - reference clock, synchronous active-high reset
//   LOOP_BACK           - asynchronous signal under measurement
//   START, ABORT        - begin / cancel a measurement
//   WINDOW              - window length in CLK cycles, captured with START
//   BUSY                - high whenever the FSM is not idle
//   DONE                - one-cycle completion pulse
//   COUNT, SATURATED    - result of the last completed window
module aha_loop_back_monitor
  import aha_loop_back_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  // Window field width. Tracks CNT_W unless overridden; a narrow edge
  // counter can then still be exercised with a long window.
  parameter int WIN_W       = CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOOP_BACK,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             SATURATED
);

  state_e             r_state, w_next;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic [CNT_W-1:0]   r_count;
  logic               r_sat;
  logic               w_edge;

  aha_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK     (CLK),
    .RESET   (RESET),
    .D_ASYNC (LOOP_BACK),
    .EDGE    (w_edge)
  );

  // Saturating edge counter update; only committed while measuring.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (w_edge) begin
      if (r_cnt == '1) w_ovf_nxt = 1'b1;
      else             w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (START) w_next = ST_ARM;
      ST_ARM: begin
        if (ABORT)             w_next = ST_IDLE;
        else if (r_win != '0)  w_next = ST_MEASURE;
        else                   w_next = ST_REPORT;
      end
      ST_MEASURE: begin
        if (ABORT)                    w_next = ST_IDLE;
        else if (r_rem == WIN_W'(1))  w_next = ST_REPORT;
      end
      ST_REPORT:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (START) r_win <= WINDOW;
        ST_ARM: begin
          r_rem <= r_win;
          r_cnt <= '0;
          r_ovf <= 1'b0;
          if (w_next == ST_REPORT) begin
            r_count <= '0;
            r_sat   <= 1'b0;
          end
        end
        ST_MEASURE: begin
          r_rem <= r_rem - WIN_W'(1);
          r_cnt <= w_cnt_nxt;
          r_ovf <= w_ovf_nxt;
          // Result is loaded on entry to REPORT so it is already valid
          // in the DONE cycle; this folds in an edge on the last cycle.
          if (w_next == ST_REPORT) begin
            r_count <= w_cnt_nxt;
            r_sat   <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = (r_state == ST_REPORT);
  assign COUNT     = r_count;
  assign SATURATED = r_sat;

endmodule
